control_fsm: RTL and testbench



---
 rtl/control_fsm.sv | 233 +++++++++++++++++++++++
 tb/tb_control_fsm.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : control_fsm
// Brief    : Registered multi-cycle control unit for the 16-bit RISC core.
//            Decodes the 8-bit instruction into datapath, PC and memory
//            controls, with post-branch bubbles, LD/ST RAM handshake and a
//            HALT state entered on EOE.
// Revision : 1.0 - initial release
// ============================================================================
module control_fsm #(
  parameter int unsigned BUBBLES = 1,    // bubble cycles after a control transfer (1..15)
  parameter bit          MEM_HS  = 1'b1  // 1: LD/ST wait for mem_ready
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] instr_i,
  input  logic       Z_i,
  input  logic       mem_ready_i,
  input  logic       resume_i,
  output logic [3:0] FS_o,
  output logic [1:0] PS_o,
  output logic [1:0] MB_o,
  output logic       MW_o,
  output logic       RW_o,
  output logic       MD_o,
  output logic       ROM_enable_o,
  output logic       ASEL_o,
  output logic       ram_rd_o,
  output logic       halted_o,
  output logic [1:0] fsm_state_o
);

  // State encoding matches the fsm_state output directly.
  localparam logic [1:0] ST_EXEC    = 2'b00;
  localparam logic [1:0] ST_BUBBLE  = 2'b01;
  localparam logic [1:0] ST_MEMWAIT = 2'b10;
  localparam logic [1:0] ST_HALT    = 2'b11;

  // PC select codes.
  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_TGT  = 2'b10;
  localparam logic [1:0] PS_REG  = 2'b11;

  // B-mux codes.
  localparam logic [1:0] MB_REG = 2'b00;
  localparam logic [1:0] MB_IMM = 2'b01;
  localparam logic [1:0] MB_RET = 2'b10;

  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_LD  = 4'h9;
  localparam logic [3:0] OP_ST  = 4'hA;
  localparam logic [3:0] OP_BZ  = 4'hB;
  localparam logic [3:0] OP_BNZ = 4'hC;
  localparam logic [3:0] OP_JAL = 4'hD;
  localparam logic [3:0] OP_J   = 4'hE;
  localparam logic [3:0] OP_SYS = 4'hF;

  // The counter reloads with BUBBLES-1 so that the cycle where it reads 0 is
  // the last bubble.
  localparam logic [3:0] BCNT_LOAD = 4'(BUBBLES - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] bcnt_q,  bcnt_d;

  logic [3:0] opcode;
  logic [3:0] field;
  logic       mem_done;

  assign opcode   = instr_i[7:4];
  assign field    = instr_i[3:0];
  // Without the handshake every LD/ST finishes in its issue cycle.
  assign mem_done = (MEM_HS == 1'b0) || mem_ready_i;

  assign FS_o        = opcode;
  assign fsm_state_o = state_q;

  // Mealy decode of outputs and next state; reset forces every control to 0.
  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    PS_o         = PS_HOLD;
    MB_o         = MB_REG;
    MW_o         = 1'b0;
    RW_o         = 1'b0;
    MD_o         = 1'b0;
    ROM_enable_o = 1'b0;
    ASEL_o       = 1'b0;
    ram_rd_o     = 1'b0;
    halted_o     = 1'b0;

    case (state_q)
      ST_EXEC: begin
        if (opcode < OP_LDI) begin
          RW_o         = 1'b1;
          PS_o         = PS_INC;
          ROM_enable_o = 1'b1;
        end else begin
          case (opcode)
            OP_LDI: begin
              RW_o         = 1'b1;
              PS_o         = PS_INC;
              MB_o         = MB_IMM;
              ROM_enable_o = 1'b1;
            end
            OP_LD: begin
              ram_rd_o = 1'b1;
              MD_o     = 1'b1;
              if (mem_done) begin
                RW_o         = 1'b1;
                PS_o         = PS_INC;
                ROM_enable_o = 1'b1;
              end else begin
                state_d = ST_MEMWAIT;
              end
            end
            OP_ST: begin
              MW_o = 1'b1;
              if (mem_done) begin
                PS_o         = PS_INC;
                ROM_enable_o = 1'b1;
              end else begin
                state_d = ST_MEMWAIT;
              end
            end
            OP_BZ: begin
              ASEL_o  = 1'b1;
              PS_o    = Z_i ? PS_TGT : PS_HOLD;
              state_d = ST_BUBBLE;
              bcnt_d  = BCNT_LOAD;
            end
            OP_BNZ: begin
              ASEL_o  = 1'b1;
              PS_o    = Z_i ? PS_HOLD : PS_TGT;
              state_d = ST_BUBBLE;
              bcnt_d  = BCNT_LOAD;
            end
            OP_JAL: begin
              RW_o    = 1'b1;
              MB_o    = MB_RET;
              PS_o    = PS_TGT;
              state_d = ST_BUBBLE;
              bcnt_d  = BCNT_LOAD;
            end
            OP_J: begin
              PS_o    = PS_TGT;
              state_d = ST_BUBBLE;
              bcnt_d  = BCNT_LOAD;
            end
            OP_SYS: begin
              if (field == 4'h0) begin
                // JR
                PS_o    = PS_REG;
                state_d = ST_BUBBLE;
                bcnt_d  = BCNT_LOAD;
              end else begin
                // EOE
                ram_rd_o = 1'b1;
                state_d  = ST_HALT;
              end
            end
            default: begin
            end
          endcase
        end
      end

      ST_MEMWAIT: begin
        // The instruction is held by PS=00, so the opcode still tells LD from ST.
        if (opcode == OP_LD) begin
          ram_rd_o = 1'b1;
          MD_o     = 1'b1;
          RW_o     = mem_ready_i;
        end else begin
          MW_o = 1'b1;
        end
        if (mem_ready_i) begin
          PS_o         = PS_INC;
          ROM_enable_o = 1'b1;
          state_d      = ST_EXEC;
        end
      end

      ST_BUBBLE: begin
        ROM_enable_o = 1'b1;
        if (bcnt_q == 4'd0) begin
          PS_o    = PS_INC;
          state_d = ST_EXEC;
        end else begin
          bcnt_d = bcnt_q - 4'd1;
        end
      end

      ST_HALT: begin
        halted_o = 1'b1;
        if (resume_i) begin
          PS_o         = PS_INC;
          ROM_enable_o = 1'b1;
          state_d      = ST_EXEC;
        end
      end

      default: begin
        state_d = ST_EXEC;
      end
    endcase

    if (rst) begin
      PS_o         = PS_HOLD;
      MB_o         = MB_REG;
      MW_o         = 1'b0;
      RW_o         = 1'b0;
      MD_o         = 1'b0;
      ROM_enable_o = 1'b0;
      ASEL_o       = 1'b0;
      ram_rd_o     = 1'b0;
      halted_o     = 1'b0;
    end
  end

  // State and bubble counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EXEC;
      bcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_fsm
// Brief    : Self-checking bench for control_fsm (BUBBLES=3, MEM_HS=1):
//            directed scenarios with literal expectations, then random
//            stimulus checked every cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_fsm;

  localparam int unsigned BUBBLES = 3;
  localparam bit          MEM_HS  = 1'b1;

  typedef struct packed {
    logic [1:0] ps;
    logic [1:0] mb;
    logic       mw;
    logic       rw;
    logic       md;
    logic       rom;
    logic       asel;
    logic       rd;
    logic       hlt;
  } ctrl_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] instr = 8'h23;
  logic       Z = 1'b0;
  logic       mem_ready = 1'b0;
  logic       resume = 1'b0;

  logic [3:0] FS;
  logic [1:0] PS, MB, fsm_state;
  logic       MW, RW, MD, ROM_enable, ASEL, ram_rd, halted;

  int n_chk  = 0;
  int n_fail = 0;

  control_fsm #(.BUBBLES(BUBBLES), .MEM_HS(MEM_HS)) dut (
    .clk(clk), .rst(rst), .instr_i(instr), .Z_i(Z), .mem_ready_i(mem_ready),
    .resume_i(resume), .FS_o(FS), .PS_o(PS), .MB_o(MB), .MW_o(MW), .RW_o(RW),
    .MD_o(MD), .ROM_enable_o(ROM_enable), .ASEL_o(ASEL), .ram_rd_o(ram_rd),
    .halted_o(halted), .fsm_state_o(fsm_state)
  );

  always #5 clk = ~clk;

  ctrl_t act;
  assign act = {PS, MB, MW, RW, MD, ROM_enable, ASEL, ram_rd, halted};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic ctrl_t mk(input logic [1:0] ps, input logic [1:0] mb,
                               input logic mw, input logic rw, input logic md,
                               input logic rom, input logic asel, input logic rd,
                               input logic hlt);
    return {ps, mb, mw, rw, md, rom, asel, rd, hlt};
  endfunction

  // Behavioural model: remaining bubble cycles, waiting-for-RAM and halted flags.
  int unsigned m_bub = 0, n_bub = 0;
  bit m_wait = 1'b0, n_wait = 1'b0;
  bit m_halt = 1'b0, n_halt = 1'b0;

  always @(negedge clk) begin
    automatic ctrl_t       e   = '0;
    automatic logic [1:0]  est = 2'd0;
    automatic int unsigned nb  = m_bub;
    automatic bit          nw  = m_wait;
    automatic bit          nh  = m_halt;
    automatic logic [3:0]  op  = instr[7:4];
    automatic bit          done = (MEM_HS == 1'b0) || mem_ready;

    if (m_halt)          est = 2'd3;
    else if (m_wait)     est = 2'd2;
    else if (m_bub != 0) est = 2'd1;

    if (rst) begin
      est = 2'd0; nb = 0; nw = 1'b0; nh = 1'b0;
    end else if (m_halt) begin
      e.hlt = 1'b1;
      if (resume) begin e.ps = 2'd1; e.rom = 1'b1; nh = 1'b0; end
    end else if (m_wait) begin
      if (op == 4'h9) begin e.rd = 1'b1; e.md = 1'b1; end
      else e.mw = 1'b1;
      if (mem_ready) begin
        e.rw = (op == 4'h9); e.ps = 2'd1; e.rom = 1'b1; nw = 1'b0;
      end
    end else if (m_bub != 0) begin
      e.rom = 1'b1;
      if (m_bub == 1) e.ps = 2'd1;
      nb = m_bub - 1;
    end else begin
      if (op <= 4'h8) begin
        e.rw = 1'b1; e.ps = 2'd1; e.rom = 1'b1;
        if (op == 4'h8) e.mb = 2'd1;
      end else if (op == 4'h9 || op == 4'hA) begin
        if (op == 4'h9) begin e.rd = 1'b1; e.md = 1'b1; end
        else e.mw = 1'b1;
        if (done) begin e.rw = (op == 4'h9); e.ps = 2'd1; e.rom = 1'b1; end
        else nw = 1'b1;
      end else if (op == 4'hF && instr[3:0] != 4'h0) begin
        e.rd = 1'b1; nh = 1'b1;
      end else begin
        nb = BUBBLES;
        case (op)
          4'hB: begin e.asel = 1'b1; e.ps = Z ? 2'd2 : 2'd0; end
          4'hC: begin e.asel = 1'b1; e.ps = Z ? 2'd0 : 2'd2; end
          4'hD: begin e.rw = 1'b1; e.mb = 2'd2; e.ps = 2'd2; end
          4'hE: e.ps = 2'd2;
          default: e.ps = 2'd3;
        endcase
      end
    end

    chk("model_cycle", {15'd0, FS, act, fsm_state}, {15'd0, instr[7:4], e, est});
    n_bub  <= nb;
    n_wait <= nw;
    n_halt <= nh;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_bub <= 0; m_wait <= 1'b0; m_halt <= 1'b0;
    end else begin
      m_bub <= n_bub; m_wait <= n_wait; m_halt <= n_halt;
    end
  end

  // Apply one cycle of inputs just after the edge, return at the following negedge.
  task automatic step(input logic [7:0] i, input logic z, input logic mr,
                      input logic res, input logic r);
    @(posedge clk);
    #1;
    instr = i; Z = z; mem_ready = mr; resume = res; rst = r;
    @(negedge clk);
  endtask

  initial begin
    // Reset with an ALU instruction present.
    @(negedge clk);
    chk("rst_ctrl", act, '0);
    chk("rst_fs", FS, 4'h2);
    step(8'h23, 0, 0, 0, 0);
    chk("alu_ctrl", act, mk(2'd1, 2'd0, 0, 1, 0, 1, 0, 0, 0));
    chk("alu_state", fsm_state, 2'd0);

    // LD with handshake: issue, two waits, completion.
    step(8'h91, 0, 0, 0, 0);
    chk("ld_issue", act, mk(2'd0, 2'd0, 0, 0, 1, 0, 0, 1, 0));
    for (int k = 0; k < 2; k++) begin
      step(8'h91, 0, 0, 0, 0);
      chk("ld_wait", act, mk(2'd0, 2'd0, 0, 0, 1, 0, 0, 1, 0));
      chk("ld_wait_state", fsm_state, 2'd2);
    end
    step(8'h91, 0, 1, 0, 0);
    chk("ld_done", act, mk(2'd1, 2'd0, 0, 1, 1, 1, 0, 1, 0));
    step(8'h23, 0, 0, 0, 0);
    chk("ld_back_exec", fsm_state, 2'd0);

    // BZ taken then three bubbles: PS 00, 00, 01.
    step(8'hB0, 1, 0, 0, 0);
    chk("bz_exec", act, mk(2'd2, 2'd0, 0, 0, 0, 0, 1, 0, 0));
    for (int k = 0; k < 3; k++) begin
      step(8'h00, 0, 0, 0, 0);
      chk("bz_bubble", act, mk((k == 2) ? 2'd1 : 2'd0, 2'd0, 0, 0, 0, 1, 0, 0, 0));
      chk("bz_bubble_state", fsm_state, 2'd1);
    end

    // BNZ not taken.
    step(8'hC0, 1, 0, 0, 0);
    chk("bnz_exec", act, mk(2'd0, 2'd0, 0, 0, 0, 0, 1, 0, 0));
    for (int k = 0; k < 3; k++) begin
      step(8'h00, 0, 0, 0, 0);
      chk("bnz_bubble", act, mk((k == 2) ? 2'd1 : 2'd0, 2'd0, 0, 0, 0, 1, 0, 0, 0));
    end

    // JAL.
    step(8'hD5, 0, 0, 0, 0);
    chk("jal_exec", act, mk(2'd2, 2'd2, 0, 1, 0, 0, 0, 0, 0));
    step(8'hD5, 0, 0, 0, 0);
    chk("jal_bubble_rw", RW, 1'b0);
    step(8'h00, 0, 0, 0, 0);
    step(8'h00, 0, 0, 0, 0);

    // EOE, five halted cycles, resume.
    step(8'hF3, 0, 0, 0, 0);
    chk("eoe_exec", act, mk(2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0));
    for (int k = 0; k < 5; k++) begin
      step(8'h23, 0, 1, 0, 0);
      chk("halt_ctrl", act, mk(2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1));
      chk("halt_state", fsm_state, 2'd3);
    end
    step(8'h23, 0, 0, 1, 0);
    chk("resume_ctrl", act, mk(2'd1, 2'd0, 0, 0, 0, 1, 0, 0, 1));
    step(8'h23, 0, 0, 0, 0);
    chk("resume_exec", fsm_state, 2'd0);

    // Reset in the middle of MEMWAIT.
    step(8'h91, 0, 0, 0, 0);
    step(8'h91, 0, 0, 0, 0);
    chk("memwait_pre_rst", fsm_state, 2'd2);
    step(8'h91, 0, 1, 0, 1);
    chk("memwait_rst_ctrl", act, '0);
    chk("memwait_rst_state", fsm_state, 2'd0);
    step(8'h23, 0, 0, 0, 0);
    chk("memwait_rst_after", act, mk(2'd1, 2'd0, 0, 1, 0, 1, 0, 0, 0));

    // Reset together with resume while halted.
    step(8'hF1, 0, 0, 0, 0);
    step(8'h23, 0, 0, 0, 0);
    chk("halt2_state", fsm_state, 2'd3);
    step(8'h23, 0, 0, 1, 1);
    chk("rst_resume_ctrl", act, '0);
    step(8'h23, 0, 0, 0, 0);
    chk("rst_resume_state", fsm_state, 2'd0);

    // Single-cycle ST.
    step(8'hA2, 0, 1, 0, 0);
    chk("st_single", act, mk(2'd1, 2'd0, 1, 0, 0, 1, 0, 0, 0));
    step(8'h23, 0, 0, 0, 0);
    chk("st_state", fsm_state, 2'd0);

    // Random traffic checked by the model on every cycle.
    for (int k = 0; k < 3000; k++) begin
      step(8'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(3) == 0),
           ($urandom_range(63) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
